alu_mdu_seq: RTL
================

Name: alu_mdu_seq

Overview:
Parametrised sequential successor to the core's combinational ALU. It keeps the base ALU op set and branch-taken evaluation and adds RV-M multiply/divide. Operands enter through a valid/ready handshake and results leave through one, so the pipeline can stall on multi-cycle divides. It sits in the EX stage and is shared by integer and branch instructions.

Parameters:
XLEN, 32, datapath width in bits (power of two, >=8)
SHW, $clog2(XLEN), shift-amount width taken from operandB[SHW-1:0]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill in-flight op; no result produced
in_valid  in  1  request valid
in_ready  out  1  block can accept request
alu_fn  in  5  operation select
btype  in  1  request is a conditional branch
bneq  in  1  with btype & SUB: branch-not-equal
operandA  in  XLEN  source A
operandB  in  XLEN  source B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
btaken  out  1  registered branch-taken flag

Behaviour:
- Clocking: clk is the only clock. rst is synchronous and active-high. Reset: state=IDLE, out_valid=0, result=0, btaken=0, in_ready=1.
- Base ops, alu_fn[4]=0:
  - 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1001 SGT, 1010 SGTU, 1101 SRA.
  - Other codes give result=0.
  - Compare results are zero-extended 0/1.
- M ops, alu_fn[4]=1: 10000 MUL (low XLEN), 10001 MULH (s*s high), 10010 MULHSU (s*u high), 10011 MULHU (u*u high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. Codes 11xxx give result=0 with 1-cycle latency.
- btaken (0 unless btype=1):
  - SUB: bneq ? (A!=B) : (A==B).
  - SLT/SLTU: compare result.
  - SGT/SGTU: compare result OR A==B (i.e. >=).
  - Any other op: 0.
  - M ops always give btaken=0.
- FSM states: IDLE, DIV, DONE.
  - IDLE with in_valid & in_ready (accept, cycle T):
    - Base ops, MUL*, div-by-zero and signed overflow go to DONE at T+1.
    - Other DIV/REM ops go to DIV.
  - DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, XLEN iterations, then DONE. out_valid rises at T+XLEN+1.
  - DONE: out_valid=1. result and btaken stay stable until out_ready=1.
    - out_ready=1 with no new accept: next state IDLE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back single-cycle ops at full throughput.
- Operands are captured at accept. Later input changes have no effect.
- Divide special cases:
  - DIV/DIVU by 0: quotient all ones. REM/REMU by 0: remainder = dividend.
  - DIV of most-negative by -1: quotient = dividend; REM gives 0.
  - All special cases complete in 1 cycle.
- Signed divide sign rules: quotient is negative iff operand signs differ and divisor != 0. Remainder takes the dividend's sign.
- flush:
  - Any state goes to IDLE next cycle and out_valid=0.
  - flush wins over a simultaneous accept; that request is dropped.
  - result holds its last value.
- rst mid-divide: abort, all outputs take reset values.
- out_valid never drops without out_ready or flush.

Test Plan:
- Reset then ADD A=0x7FFFFFFF, B=1, out_ready=1 -> result=0x80000000 at T+1, btaken=0; follow-on SRA A=0x80000000, B=4 issued at T+1 -> result=0xF8000000 at T+2.
- Branch checks:
  - SUB, btype=1, bneq=0, A=B=5 -> btaken=1.
  - Same with bneq=1 -> btaken=0.
  - SGT A=3, B=3 -> btaken=1.
- MULH A=0xFFFFFFFF (-1), B=2 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001; MUL -> 0xFFFFFFFE.
- Divide cases:
  - DIV A=-7, B=2 -> -3 (0xFFFFFFFD), out_valid exactly at T+33.
  - REM A=-7, B=2 -> -1.
  - DIVU A=7, B=0 -> 0xFFFFFFFF at T+1.
  - DIV A=0x80000000, B=-1 -> 0x80000000 at T+1.
- Hold out_ready=0 for 5 cycles after DONE -> result/out_valid stable, in_ready=0; raise out_ready -> in_ready=1 same cycle.
- Abort cases:
  - flush at T+10 of DIVU -> out_valid stays 0; IDLE at T+11.
  - rst at T+5 of another divide -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage issue logic and the ALU/MDU.
// The master issues operations and consumes results; the slave is the unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_fn;
  logic            btype;
  logic            bneq;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            btaken;

  modport master (
    output flush, in_valid, alu_fn, btype, bneq, operandA, operandB, out_ready,
    input  in_ready, out_valid, result, btaken
  );

  modport slave (
    input  flush, in_valid, alu_fn, btype, bneq, operandA, operandB, out_ready,
    output in_ready, out_valid, result, btaken
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Sequential ALU with RV-M multiply/divide and branch-taken evaluation.
// Base ops, multiplies and divide special cases finish in one cycle; regular
// divides run a restoring radix-2 loop on magnitudes, one bit per cycle.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SGT  = 4'b1001;
  localparam logic [3:0] OP_SGTU = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when n is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  state_t state, state_n;

  logic [XLEN-1:0] a, b;
  logic [4:0]      fn;
  logic [SHW-1:0]  shamt;
  logic            lt, ltu, gt, gtu, eq;

  assign a     = bus.operandA;
  assign b     = bus.operandB;
  assign fn    = bus.alu_fn;
  assign shamt = b[SHW-1:0];
  assign lt    = $signed(a) < $signed(b);
  assign ltu   = a < b;
  assign gt    = $signed(a) > $signed(b);
  assign gtu   = a > b;
  assign eq    = (a == b);

  logic [XLEN-1:0] base_res;
  logic            base_bt;

  // Base ALU result and branch condition from the live request operands.
  always_comb begin
    base_res = '0;
    base_bt  = 1'b0;
    case (fn[3:0])
      OP_ADD:  base_res = a + b;
      OP_SLL:  base_res = a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, ltu};
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = a >> shamt;
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      OP_SUB:  base_res = a - b;
      OP_SGT:  base_res = {{(XLEN-1){1'b0}}, gt};
      OP_SGTU: base_res = {{(XLEN-1){1'b0}}, gtu};
      OP_SRA:  base_res = $signed(a) >>> shamt;
      default: base_res = '0;
    endcase
    if (bus.btype) begin
      case (fn[3:0])
        OP_SUB:  base_bt = bus.bneq ? ~eq : eq;
        OP_SLT:  base_bt = lt;
        OP_SLTU: base_bt = ltu;
        OP_SGT:  base_bt = gt | eq;
        OP_SGTU: base_bt = gtu | eq;
        default: base_bt = 1'b0;
      endcase
    end
  end

  logic                   mul_a_sgn, mul_b_sgn;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]        mul_res;

  // Full-width product; operand signedness picked by MULH/MULHSU/MULHU.
  always_comb begin
    mul_a_sgn = (fn[1:0] == 2'b01) | (fn[1:0] == 2'b10);
    mul_b_sgn = (fn[1:0] == 2'b01);
    mul_a     = {{XLEN{mul_a_sgn & a[XLEN-1]}}, a};
    mul_b     = {{XLEN{mul_b_sgn & b[XLEN-1]}}, b};
    prod      = mul_a * mul_b;
    mul_res   = (fn[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  logic div_sgn, div_rem, div_zero, div_ovf, go_div;
  logic [XLEN-1:0] single_res;
  logic            single_bt;

  assign div_sgn  = ~fn[0];
  assign div_rem  = fn[1];
  assign div_zero = (b == '0);
  assign div_ovf  = div_sgn & (a == XMIN) & (b == '1);
  assign go_div   = fn[4] & ~fn[3] & fn[2] & ~div_zero & ~div_ovf;

  // Result of every op that completes in the cycle after accept.
  always_comb begin
    single_res = '0;
    if (!fn[4])
      single_res = base_res;
    else if (fn[3])
      single_res = '0;
    else if (!fn[2])
      single_res = mul_res;
    else if (div_zero)
      single_res = div_rem ? a : '1;
    else
      single_res = div_rem ? '0 : a;
  end
  assign single_bt = ~fn[4] & base_bt;

  logic [XLEN-1:0] quo_p1, rem_p1, dvs_p1;
  logic            negq_p1, negr_p1, isrem_p1;
  logic [SHW-1:0]  cnt_p1;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] nquo, nrem, div_res;

  // One restoring step plus the sign fix-up applied on the final step.
  always_comb begin
    shifted = {rem_p1, quo_p1[XLEN-1]};
    trial   = shifted - {1'b0, dvs_p1};
    if (trial[XLEN]) begin
      nrem = shifted[XLEN-1:0];
      nquo = {quo_p1[XLEN-2:0], 1'b0};
    end else begin
      nrem = trial[XLEN-1:0];
      nquo = {quo_p1[XLEN-2:0], 1'b1};
    end
    div_res = isrem_p1 ? cond_neg(nrem, negr_p1) : cond_neg(nquo, negq_p1);
  end

  logic ready, acc, fin;

  // Next-state and handshake decode; flush overrides any accept.
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      DIV: begin
        if (cnt_p1 == SHW'(XLEN-1)) begin
          fin     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ready = bus.out_ready;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    acc = bus.in_valid & ready & ~bus.flush;
    if (acc) state_n = go_div ? DIV : DONE;
    if (bus.flush) begin
      state_n = IDLE;
      fin     = 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == DONE);

  // Control state and divide iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p1 <= '0;
    end else begin
      state <= state_n;
      if (acc)
        cnt_p1 <= '0;
      else if (state == DIV)
        cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // ---- stage p1: divider operands captured at accept, then iterated ----
  always_ff @(posedge clk) begin
    if (acc) begin
      quo_p1   <= cond_neg(a, div_sgn & a[XLEN-1]);
      dvs_p1   <= cond_neg(b, div_sgn & b[XLEN-1]);
      rem_p1   <= '0;
      negq_p1  <= div_sgn & (a[XLEN-1] ^ b[XLEN-1]);
      negr_p1  <= div_sgn & a[XLEN-1];
      isrem_p1 <= div_rem;
    end else if (state == DIV) begin
      quo_p1 <= nquo;
      rem_p1 <= nrem;
    end
  end

  // ---- output register: single-cycle result at accept, divide at finish ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.btaken <= 1'b0;
    end else if (acc && !go_div) begin
      bus.result <= single_res;
      bus.btaken <= single_bt;
    end else if (fin) begin
      bus.result <= div_res;
      bus.btaken <= 1'b0;
    end
  end

endmodule
